mips_run_ctrl: RTL and testbench
================================

Name: mips_run_ctrl

Overview:
- Parametrised run controller for CPU-under-test instances (single-cycle or pipelined MIPS cores).
- Replaces fixed reset-pulse and fixed-duration run control with a clocked FSM. The FSM holds cores in reset for a programmable number of cycles, then counts run cycles.
- Each core is detected as halted when its PC holds the same value for STALL_LIMIT consecutive cycles (jump-to-self idiom).
- The run ends on all-halted or on cycle timeout.
- Sits between the bench clock/reset source and N_CORES core instances.

Parameters:
- N_CORES, 1, number of cores monitored (>=1).
- PC_W, 32, PC width per core.
- RESET_CYCLES, 5, cycles core_reset is held after start (>=1).
- MAX_CYCLES, 3250, run-cycle limit before timeout (>=1).
- STALL_LIMIT, 8, consecutive identical-PC cycles that mark a core halted (>=2).
- CNT_W, 32, cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; honoured in IDLE and DONE only.
- pc  in  N_CORES*PC_W  core PCs, flattened; core i occupies bits [i*PC_W +: PC_W].
- core_reset  out  1  reset to cores; high except in RUN.
- running  out  1  high in RUN.
- halted  out  N_CORES  sticky per-core halt flags.
- done  out  1  high in DONE.
- timeout  out  1  run ended by MAX_CYCLES rather than by all-halted; valid while done.
- cycle_count  out  CNT_W  RUN cycles elapsed; frozen in DONE.

Behaviour:
- Reset handling: reset is sampled on clk only (synchronous, active-high). Reset forces:
  - state = IDLE;
  - core_reset = 1;
  - running = 0, done = 0, timeout = 0;
  - halted = 0, cycle_count = 0;
  - hold counter = 0, per-core same-PC counters = 0.
- Reset wins over every other input in the same cycle. Reset asserted mid-HOLD/RUN/DONE returns to IDLE at the next edge.
- IDLE: core_reset = 1. start = 1 -> HOLD, with hold counter cleared.
- HOLD:
  - core_reset = 1 for exactly RESET_CYCLES cycles, counted from the first HOLD cycle.
  - After the last HOLD cycle -> RUN.
  - start is ignored.
- RUN:
  - Outputs: core_reset = 0, running = 1.
  - cycle_count increments by 1 at the end of every RUN cycle, including the last. It saturates at 2^CNT_W-1.
  - Per-core stall detection:
    - A registered last_pc[i] and same_cnt[i] are kept per core.
    - First RUN cycle: same_cnt = 1.
    - Later cycles: same_cnt = same_cnt+1 if pc[i] == last_pc[i], else 1.
    - last_pc[i] <= pc[i] every RUN cycle.
    - When the next value of same_cnt reaches STALL_LIMIT, halted[i] sets at that edge. It is sticky until the next start or reset. Counters saturate at STALL_LIMIT.
  - End condition: evaluated each RUN cycle using next-halted (registered halted OR newly set bits).
    - If all N_CORES bits are set -> DONE, timeout = 0.
    - Else if cycle_count == MAX_CYCLES-1 (this is RUN cycle number MAX_CYCLES) -> DONE, timeout = 1.
    - Simultaneous all-halted and limit: halt wins, timeout = 0.
  - start is ignored.
- DONE:
  - Outputs: done = 1, running = 0, core_reset = 1.
  - halted, timeout and cycle_count are held.
  - start = 1 -> HOLD; clears done, timeout, halted, cycle_count and the per-core counters at that edge.
- Outputs are registered or decoded from registered state only. There is no combinational path from pc or start to any output.

Test Plan:
1. Timeout run. Params N_CORES=1, MAX_CYCLES=20, RESET_CYCLES=5. Stimulus: reset 5 cycles, start pulse, pc incrementing by 4 each cycle from 0x00003000. Required response:
   - core_reset high for exactly 5 cycles after start;
   - then running for 20 cycles;
   - then done=1, timeout=1, cycle_count=20, halted=0.
2. Single-core halt. Params STALL_LIMIT=8, MAX_CYCLES=100. Stimulus: pc incrementing, then constant at 0x00003010 from RUN cycle 10. Required response:
   - halted[0] rises after RUN cycle 17;
   - DONE is entered at the same edge;
   - cycle_count=17, timeout=0.
3. Two-core halt. Params N_CORES=2. Stimulus: core0 sticks from RUN cycle 3, core1 from RUN cycle 30. Required response:
   - halted=2'b01 after cycle 10;
   - done stays 0 until cycle 37;
   - then halted=2'b11, cycle_count=37.
4. Halt and limit in the same cycle. Params MAX_CYCLES=17, pc as in scenario 2. Required response: done=1, timeout=0.
5. Non-halting loop. Stimulus: pc alternates 0x3000/0x3004. Required response: halted never sets; timeout=1 at MAX_CYCLES.
6. Control sequencing:
   - start pulsed in RUN: no effect.
   - reset asserted at RUN cycle 7: the next cycle shows core_reset=1, running=0, cycle_count=0, halted=0.
   - start in DONE: done clears, and a new 5-cycle HOLD begins.

Source files
------------

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_run_ctrl: holds cores in reset, runs them, detects jump-to-self halt|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_run_ctrl #(
  parameter int N_CORES      = 1,
  parameter int PC_W         = 32,
  parameter int RESET_CYCLES = 5,
  parameter int MAX_CYCLES   = 3250,
  parameter int STALL_LIMIT  = 8,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_CORES*PC_W-1:0]   pc,
  output logic                      core_reset,
  output logic                      running,
  output logic [N_CORES-1:0]        halted,
  output logic                      done,
  output logic                      timeout,
  output logic [CNT_W-1:0]          cycle_count
);

  localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam int SAME_W = $clog2(STALL_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [SAME_W-1:0] SAME_MAX  = SAME_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                               state, state_nxt;
  logic [HOLD_W-1:0]                    hold_cnt;
  logic [N_CORES-1:0][PC_W-1:0]         last_pc;
  logic [N_CORES-1:0][SAME_W-1:0]       same_cnt;
  logic [N_CORES-1:0][SAME_W-1:0]       same_nxt;
  logic [N_CORES-1:0]                   halted_nxt;
  logic                                 first_run;
  logic                                 end_timeout;

  // cycle_count only reads zero during the first RUN cycle of a run
  assign first_run = (cycle_count == '0);

  always_comb begin
    same_nxt   = '0;
    halted_nxt = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (first_run || (pc[i*PC_W +: PC_W] != last_pc[i])) begin
        same_nxt[i] = SAME_W'(1);
      end else if (same_cnt[i] >= SAME_MAX) begin
        same_nxt[i] = SAME_MAX;
      end else begin
        same_nxt[i] = same_cnt[i] + SAME_W'(1);
      end
      halted_nxt[i] = halted[i] | (same_nxt[i] == SAME_MAX);
    end
  end

  always_comb begin
    state_nxt   = state;
    end_timeout = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_HOLD;
      S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      S_RUN: begin
        // all-halted takes priority over the cycle limit
        if (&halted_nxt) begin
          state_nxt = S_DONE;
        end else if (cycle_count == CNT_LAST) begin
          state_nxt   = S_DONE;
          end_timeout = 1'b1;
        end
      end
      S_DONE: if (start) state_nxt = S_HOLD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      halted      <= '0;
      timeout     <= 1'b0;
      last_pc     <= '0;
      same_cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            hold_cnt    <= '0;
            cycle_count <= '0;
            halted      <= '0;
            timeout     <= 1'b0;
            same_cnt    <= '0;
          end
        end
        S_HOLD: hold_cnt <= hold_cnt + HOLD_W'(1);
        S_RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
          halted   <= halted_nxt;
          same_cnt <= same_nxt;
          last_pc  <= pc;
          if (state_nxt == S_DONE) timeout <= end_timeout;
        end
        default: ;
      endcase
    end
  end

  assign core_reset = (state != S_RUN);
  assign running    = (state == S_RUN);
  assign done       = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// Bench for mips_run_ctrl: four instances with different core counts/limits,
// checked every cycle against a pc-history model plus literal expectations.
module tb_mips_run_ctrl;

  localparam int NI = 4;
  localparam int RC = 5;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0] start_v;
  logic [63:0]   pc_v [NI];
  logic [NI-1:0] cr_v, run_v, done_v, to_v;
  logic [31:0]   cc_v [NI];
  logic          h_a, h_b, h_d;
  logic [1:0]    h_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_run_ctrl #(.N_CORES(1), .MAX_CYCLES(20)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .pc(pc_v[0][31:0]),
    .core_reset(cr_v[0]), .running(run_v[0]), .halted(h_a), .done(done_v[0]),
    .timeout(to_v[0]), .cycle_count(cc_v[0]));
  mips_run_ctrl #(.N_CORES(1), .MAX_CYCLES(100)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .pc(pc_v[1][31:0]),
    .core_reset(cr_v[1]), .running(run_v[1]), .halted(h_b), .done(done_v[1]),
    .timeout(to_v[1]), .cycle_count(cc_v[1]));
  mips_run_ctrl #(.N_CORES(2), .MAX_CYCLES(100)) dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .pc(pc_v[2]),
    .core_reset(cr_v[2]), .running(run_v[2]), .halted(h_c), .done(done_v[2]),
    .timeout(to_v[2]), .cycle_count(cc_v[2]));
  mips_run_ctrl #(.N_CORES(1), .MAX_CYCLES(17)) dut_d (
    .clk(clk), .reset(reset), .start(start_v[3]), .pc(pc_v[3][31:0]),
    .core_reset(cr_v[3]), .running(run_v[3]), .halted(h_d), .done(done_v[3]),
    .timeout(to_v[3]), .cycle_count(cc_v[3]));

  function automatic logic [1:0] get_h(int i);
    case (i)
      0: return {1'b0, h_a};
      1: return {1'b0, h_b};
      2: return h_c;
      default: return {1'b0, h_d};
    endcase
  endfunction

  function automatic int n_cores(int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic int max_cyc(int i);
    case (i)
      0: return 20;
      3: return 17;
      default: return 100;
    endcase
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 hold, 2 run, 3 done; halt = last SL pcs identical
  int          m_ph   [NI];
  int          m_hold [NI];
  int          m_runs [NI];
  logic [1:0]  m_h    [NI];
  logic        m_t    [NI];
  logic [31:0] hist   [NI][2][0:127];
  bit          valid = 1'b0;

  task automatic advance(int i);
    bit same, all;
    if (reset) begin
      m_ph[i] = 0; m_runs[i] = 0; m_h[i] = 2'b00; m_t[i] = 1'b0;
    end else begin
      case (m_ph[i])
        0: if (start_v[i]) begin m_ph[i] = 1; m_hold[i] = 0; end
        1: begin
          m_hold[i]++;
          if (m_hold[i] == RC) m_ph[i] = 2;
        end
        2: begin
          m_runs[i]++;
          all = 1'b1;
          for (int c = 0; c < n_cores(i); c++) begin
            hist[i][c][m_runs[i]] = pc_v[i][c*32 +: 32];
            if (m_runs[i] >= SL) begin
              same = 1'b1;
              for (int d = 1; d < SL; d++)
                if (hist[i][c][m_runs[i]-d] != hist[i][c][m_runs[i]]) same = 1'b0;
              if (same) m_h[i][c] = 1'b1;
            end
            if (!m_h[i][c]) all = 1'b0;
          end
          if (all) begin
            m_ph[i] = 3; m_t[i] = 1'b0;
          end else if (m_runs[i] == max_cyc(i)) begin
            m_ph[i] = 3; m_t[i] = 1'b1;
          end
        end
        default: if (start_v[i]) begin
          m_ph[i] = 1; m_hold[i] = 0; m_runs[i] = 0; m_h[i] = 2'b00; m_t[i] = 1'b0;
        end
      endcase
    end
  endtask

  task automatic compare(int i);
    chk($sformatf("inst%0d core_reset", i), cr_v[i], m_ph[i] != 2);
    chk($sformatf("inst%0d running", i), run_v[i], m_ph[i] == 2);
    chk($sformatf("inst%0d done", i), done_v[i], m_ph[i] == 3);
    chk($sformatf("inst%0d timeout", i), to_v[i], m_t[i]);
    chk($sformatf("inst%0d halted", i), get_h(i), m_h[i]);
    chk($sformatf("inst%0d cycle_count", i), cc_v[i], m_runs[i]);
  endtask

  // Compare the state produced by the last edge, then step the model with the
  // inputs that the coming edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (valid) for (int i = 0; i < NI; i++) compare(i);
      for (int i = 0; i < NI; i++) advance(i);
      if (reset) valid = 1'b1;
    end
  end

  logic        ob_cr [0:127];
  logic        ob_r  [0:127];
  logic        ob_d  [0:127];
  logic        ob_t  [0:127];
  logic [1:0]  ob_h  [0:127];
  logic [31:0] ob_cc [0:127];

  function automatic logic [31:0] pcval(logic [31:0] base, int stick, bit alt, int k);
    if (alt) return k[0] ? 32'h0000_3000 : 32'h0000_3004;
    return base + 32'(4 * ((k < stick) ? k : stick));
  endfunction

  // Sample j is taken just after edge j following the start edge; RUN cycle k
  // ends at edge k+RC, so the pc set after edge j belongs to RUN cycle j-4.
  task automatic drive(int i, logic [31:0] b0, int s0, logic [31:0] b1, int s1,
                       bit alt, int ncyc, int st_at, int rs_at);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    for (int j = 0; j <= ncyc; j++) begin
      ob_cr[j] = cr_v[i]; ob_r[j] = run_v[i]; ob_d[j] = done_v[i];
      ob_t[j]  = to_v[i]; ob_h[j] = get_h(i); ob_cc[j] = cc_v[i];
      pc_v[i]    = {pcval(b1, s1, alt, j - 4), pcval(b0, s0, alt, j - 4)};
      start_v[i] = (j == st_at);
      reset      = (j == rs_at);
      @(posedge clk); #1;
    end
    start_v[i] = 1'b0;
    reset      = 1'b0;
  endtask

  function automatic int count_hold(int n);
    int c = 0;
    for (int j = 0; j <= n; j++) begin
      if (ob_r[j]) break;
      if (ob_cr[j] && !ob_d[j]) c++;
    end
    return c;
  endfunction

  function automatic int count_run(int n);
    int c = 0;
    for (int j = 0; j <= n; j++) if (ob_r[j]) c++;
    return c;
  endfunction

  initial begin
    reset   = 1'b1;
    start_v = '0;
    for (int i = 0; i < NI; i++) pc_v[i] = '0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset core_reset", cr_v[0], 1);
    chk("reset running", run_v[0], 0);
    chk("reset done", done_v[0], 0);
    chk("reset cycle_count", cc_v[0], 0);

    // Timeout run, pc 0x3000, 0x3004, ...
    drive(0, 32'h2FFC, 1000, 32'h0, 1000, 1'b0, 30, -1, -1);
    chk("t1 hold cycles", count_hold(30), 5);
    chk("t1 run cycles", count_run(30), 20);
    chk("t1 done", ob_d[30], 1);
    chk("t1 timeout", ob_t[30], 1);
    chk("t1 cycle_count", ob_cc[30], 20);
    chk("t1 halted", ob_h[30], 0);

    // Start while in DONE
    drive(0, 32'h2FFC, 1000, 32'h0, 1000, 1'b0, 30, -1, -1);
    chk("t6 done cleared", ob_d[0], 0);
    chk("t6 hold again", count_hold(30), 5);
    chk("t6 timeout again", ob_t[30], 1);

    // Single-core halt, pc constant at 0x3010 from RUN cycle 10
    drive(1, 32'h2FE8, 10, 32'h0, 1000, 1'b0, 30, -1, -1);
    chk("t2 halted before", ob_h[21], 0);
    chk("t2 halted", ob_h[22], 1);
    chk("t2 done", ob_d[22], 1);
    chk("t2 cycle_count", ob_cc[22], 17);
    chk("t2 timeout", ob_t[22], 0);

    // Two cores stick at RUN cycles 3 and 30
    drive(2, 32'h3000, 3, 32'h5000, 30, 1'b0, 50, -1, -1);
    chk("t3 halted c9", ob_h[14], 2'b00);
    chk("t3 halted c10", ob_h[15], 2'b01);
    chk("t3 done c36", ob_d[41], 0);
    chk("t3 done c37", ob_d[42], 1);
    chk("t3 halted c37", ob_h[42], 2'b11);
    chk("t3 cycle_count", ob_cc[42], 37);

    // Halt and limit on the same cycle
    drive(3, 32'h2FE8, 10, 32'h0, 1000, 1'b0, 30, -1, -1);
    chk("t4 done", ob_d[22], 1);
    chk("t4 timeout", ob_t[22], 0);
    chk("t4 cycle_count", ob_cc[22], 17);

    // Non-halting two-address loop
    drive(1, 32'h0, 1000, 32'h0, 1000, 1'b1, 110, -1, -1);
    chk("t5 done early", ob_d[104], 0);
    chk("t5 done", ob_d[105], 1);
    chk("t5 timeout", ob_t[105], 1);
    chk("t5 halted", ob_h[105], 0);
    chk("t5 cycle_count", ob_cc[105], 100);

    // start during RUN is ignored; reset at RUN cycle 7 returns to IDLE
    drive(1, 32'h2FFC, 1000, 32'h0, 1000, 1'b0, 20, 6, 11);
    chk("t6 start in run running", ob_r[7], 1);
    chk("t6 start in run count", ob_cc[7], 2);
    chk("t6 reset core_reset", ob_cr[12], 1);
    chk("t6 reset running", ob_r[12], 0);
    chk("t6 reset cycle_count", ob_cc[12], 0);
    chk("t6 reset halted", ob_h[12], 0);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
